// File: rtl/an_code_pkg.sv
// Shared AN-code helpers: residues of powers of two, syndrome lookup and the
// elaboration-time check that every single-bit error has a unique residue.
package an_code_pkg;

    localparam int MODE_HL     = 0;
    localparam int MODE_LH     = 1;
    localparam int POS_FIELD_W = 16;

    typedef struct packed {
        logic                   hit;
        logic [POS_FIELD_W-1:0] pos;
    } syn_hit_t;

    function automatic int residue_of_pow2(input int i, input int a);
        int r = 1 % a;
        for (int k = 0; k < i; k++) begin
            r = (r * 2) % a;
        end
        return r;
    endfunction

    // Residue produced by a single error at bit i in the given direction.
    function automatic int syndrome_of(input int i, input int a, input int mode);
        int p = residue_of_pow2(i, a);
        return (mode == MODE_HL) ? (a - p) % a : p;
    endfunction

    function automatic syn_hit_t syndrome_pos(input int r, input int a,
                                              input int an_w, input int mode);
        syn_hit_t s = '0;
        for (int i = 0; i < an_w; i++) begin
            if (!s.hit && syndrome_of(i, a, mode) == r) begin
                s.hit = 1'b1;
                s.pos = POS_FIELD_W'(i);
            end
        end
        return s;
    endfunction

    function automatic bit table_is_unique(input int a, input int an_w, input int mode);
        for (int i = 0; i < an_w; i++) begin
            if (syndrome_of(i, a, mode) == 0) return 1'b0;
            for (int j = 0; j < i; j++) begin
                if (syndrome_of(i, a, mode) == syndrome_of(j, a, mode)) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/an_syndrome_lut.sv
// Residue -> error position lookup; the table is fully built at elaboration.
module an_syndrome_lut
    import an_code_pkg::*;
#(
    parameter int A     = 13,
    parameter int AN_W  = 12,
    parameter int MODE  = MODE_HL,
    parameter int RES_W = $clog2(A),
    parameter int POS_W = $clog2(AN_W)
) (
    input  logic [RES_W-1:0] res_i,
    output logic             hit_o,
    output logic [POS_W-1:0] pos_o
);

    logic [A-1:0]     hit_tab;
    logic [POS_W-1:0] pos_tab [A];

    for (genvar r = 0; r < A; r++) begin : g_tab
        localparam syn_hit_t ENTRY = syndrome_pos(r, A, AN_W, MODE);
        assign hit_tab[r] = ENTRY.hit;
        assign pos_tab[r] = POS_W'(ENTRY.pos);
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        hit_o = 1'b0;
        pos_o = '0;
        if (32'(res_i) < A) begin
            hit_o = hit_tab[res_i];
            pos_o = pos_tab[res_i];
        end
    end

endmodule

// File: rtl/an_decoder_pipe.sv
// Two-stage valid/ready AN-code decoder: residue, single unidirectional error
// repair, division by A, and saturating statistics for corrected/bad words.
module an_decoder_pipe
    import an_code_pkg::*;
#(
    parameter int A     = 13,
    parameter int AN_W  = 12,
    parameter int N_W   = 8,
    parameter int MODE  = MODE_HL,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AN_W-1:0]          an_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_W-1:0]           n_out,
    output logic                     err_corr,
    output logic                     err_uncorr,
    output logic [$clog2(AN_W)-1:0]  err_pos,
    input  logic                     clr_cnt,
    output logic [CNT_W-1:0]         cnt_corr,
    output logic [CNT_W-1:0]         cnt_uncorr
);

    localparam int          RES_W       = $clog2(A);
    localparam int          POS_W       = $clog2(AN_W);
    localparam logic [31:0] A_U         = 32'(A);
    localparam logic [31:0] N_MAX       = (32'd1 << N_W) - 32'd1;
    localparam logic        REPAIR_FROM = (MODE == MODE_HL) ? 1'b0 : 1'b1;

    if (A < 3 || (A % 2) == 0) begin : g_bad_a
        $fatal(1, "an_decoder_pipe: A must be odd and >= 3");
    end
    if (MODE != MODE_HL && MODE != MODE_LH) begin : g_bad_mode
        $fatal(1, "an_decoder_pipe: MODE must be 0 or 1");
    end
    if (!table_is_unique(A, AN_W, MODE)) begin : g_bad_table
        $fatal(1, "an_decoder_pipe: syndromes not unique, AN_W exceeds ord_A(2)");
    end

    logic                   s1_valid_q, s1_valid_d;
    logic [AN_W-1:0]        s1_data_q,  s1_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [N_W-1:0]         n_q,        n_d;
    logic                   corr_q,     corr_d;
    logic                   uncorr_q,   uncorr_d;
    logic [POS_W-1:0]       pos_q,      pos_d;
    logic [CNT_W-1:0]       cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]       cnt_uncorr_q, cnt_uncorr_d;

    logic                   s2_adv;
    logic                   accept;
    logic                   fire;

    logic [RES_W-1:0]       res;
    logic                   syn_hit;
    logic [POS_W-1:0]       syn_pos;
    logic [AN_W-1:0]        anc;
    logic [31:0]            quot;
    logic [N_W-1:0]         dec_n;
    logic                   dec_corr;
    logic                   dec_uncorr;
    logic [POS_W-1:0]       dec_pos;

    // A full S1 may refill in the same cycle it drains, so no bubble appears.
    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid_q && out_ready;

    assign res = RES_W'(32'(s1_data_q) % A_U);

    an_syndrome_lut #(
        .A     (A),
        .AN_W  (AN_W),
        .MODE  (MODE),
        .RES_W (RES_W),
        .POS_W (POS_W)
    ) u_lut (
        .res_i (res),
        .hit_o (syn_hit),
        .pos_o (syn_pos)
    );

    always_comb begin
        anc        = s1_data_q;
        quot       = '0;
        dec_n      = '0;
        dec_corr   = 1'b0;
        dec_uncorr = 1'b0;
        dec_pos    = '0;
        if (res != '0) begin
            if (syn_hit && s1_data_q[syn_pos] == REPAIR_FROM) begin
                anc      = s1_data_q ^ (AN_W'(1) << syn_pos);
                dec_corr = 1'b1;
                dec_pos  = syn_pos;
            end else begin
                dec_uncorr = 1'b1;
            end
        end
        quot = 32'(anc) / A_U;
        if (quot > N_MAX) begin
            dec_uncorr = 1'b1;
            dec_n      = '1;
        end else begin
            dec_n = N_W'(quot);
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        out_valid_d  = out_valid_q;
        n_d          = n_q;
        corr_d       = corr_q;
        uncorr_d     = uncorr_q;
        pos_d        = pos_q;
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;

        if (in_ready) s1_valid_d = in_valid;
        if (accept)   s1_data_d  = an_in;

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                n_d      = dec_n;
                corr_d   = dec_corr;
                uncorr_d = dec_uncorr;
                pos_d    = dec_pos;
            end
        end

        if (clr_cnt) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (fire) begin
            if (corr_q && cnt_corr_q != '1)     cnt_corr_d   = cnt_corr_q + CNT_W'(1);
            if (uncorr_q && cnt_uncorr_q != '1) cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            out_valid_q  <= 1'b0;
            n_q          <= '0;
            corr_q       <= 1'b0;
            uncorr_q     <= 1'b0;
            pos_q        <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            out_valid_q  <= out_valid_d;
            n_q          <= n_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
            pos_q        <= pos_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign n_out      = n_q;
    assign err_corr   = corr_q;
    assign err_uncorr = uncorr_q;
    assign err_pos    = pos_q;
    assign cnt_corr   = cnt_corr_q;
    assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_an_decoder_pipe.sv
// Scoreboard bench for an_decoder_pipe: directed cases, backpressure, reset,
// counter clear/saturation, and a randomized stream against an arithmetic model.
module tb_an_decoder_pipe;

    localparam int A       = 13;
    localparam int AN_W    = 12;
    localparam int N_W     = 8;
    localparam int MODE    = 0;
    localparam int CNT_W   = 4;
    localparam int POS_W   = $clog2(AN_W);
    localparam int N_MAX   = (1 << N_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             clr_cnt = 1'b0;
    logic [AN_W-1:0]  an_in = '0;
    logic             in_ready;
    logic             out_valid;
    logic [N_W-1:0]   n_out;
    logic             err_corr;
    logic             err_uncorr;
    logic [POS_W-1:0] err_pos;
    logic [CNT_W-1:0] cnt_corr;
    logic [CNT_W-1:0] cnt_uncorr;

    typedef struct {
        int n;
        bit corr;
        bit uncorr;
        int pos;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   consumed = 0;
    int   m_cnt_corr = 0;
    int   m_cnt_uncorr = 0;
    bit   bp_rand = 1'b0;

    an_decoder_pipe #(
        .A     (A),
        .AN_W  (AN_W),
        .N_W   (N_W),
        .MODE  (MODE),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .an_in      (an_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .n_out      (n_out),
        .err_corr   (err_corr),
        .err_uncorr (err_uncorr),
        .err_pos    (err_pos),
        .clr_cnt    (clr_cnt),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: find the bit whose unidirectional flip makes the word a multiple of A.
    function automatic exp_t ref_decode(input logic [AN_W-1:0] word);
        exp_t        e;
        int unsigned ane = word;
        int unsigned anc = word;
        int unsigned r   = ane % A;
        int unsigned q;
        int          p   = -1;
        e = '{n: 0, corr: 1'b0, uncorr: 1'b0, pos: 0};
        if (r != 0) begin
            for (int i = 0; i < AN_W; i++) begin
                int unsigned w = 1 << i;
                if (MODE == 0 ? ((r + w) % A == 0) : (r == w % A)) p = i;
            end
            if (p < 0) begin
                e.uncorr = 1'b1;
            end else if (MODE == 0 && ((ane >> p) & 1) == 0) begin
                anc = ane + (1 << p); e.corr = 1'b1; e.pos = p;
            end else if (MODE == 1 && ((ane >> p) & 1) == 1) begin
                anc = ane - (1 << p); e.corr = 1'b1; e.pos = p;
            end else begin
                e.uncorr = 1'b1;
            end
        end
        q = anc / A;
        if (q > N_MAX) begin
            e.uncorr = 1'b1;
            e.n      = N_MAX;
        end else begin
            e.n = int'(q);
        end
        return e;
    endfunction

    function automatic logic [AN_W-1:0] rand_word();
        int unsigned w;
        case ($urandom_range(2))
            0:       w = $urandom_range(((1 << AN_W) - 1) / A) * A;
            1:       w = ($urandom_range(((1 << AN_W) - 1) / A) * A) ^ (1 << $urandom_range(AN_W - 1));
            default: w = $urandom_range((1 << AN_W) - 1);
        endcase
        return AN_W'(w);
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [AN_W-1:0] w);
        int waited = 0;
        in_valid = 1'b1;
        an_in    = w;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0d after %0d cycles, expected 1", in_ready, waited);
        end else begin
            sb.push_back(ref_decode(w));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin : bp_gen
        forever begin
            @(negedge clk);
            if (bp_rand) begin
                out_ready = ($urandom_range(3) != 0);
                clr_cnt   = ($urandom_range(29) == 0);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                check("cnt_corr", cnt_corr, m_cnt_corr);
                check("cnt_uncorr", cnt_uncorr, m_cnt_uncorr);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got n_out=%0d with empty scoreboard, expected no output", n_out);
                    end else begin
                        e = sb[0];
                        check("n_out", n_out, e.n);
                        check("err_corr", err_corr, e.corr);
                        check("err_uncorr", err_uncorr, e.uncorr);
                        check("err_pos", err_pos, e.pos);
                        if (out_ready) begin
                            void'(sb.pop_front());
                            consumed++;
                            if (!clr_cnt) begin
                                if (e.corr && m_cnt_corr < CNT_MAX)     m_cnt_corr++;
                                if (e.uncorr && m_cnt_uncorr < CNT_MAX) m_cnt_uncorr++;
                            end
                        end
                    end
                end
                if (clr_cnt) begin
                    m_cnt_corr   = 0;
                    m_cnt_uncorr = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int base;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_n_out", n_out, 0);
        check("rst_err_corr", err_corr, 0);
        check("rst_err_uncorr", err_uncorr, 0);
        check("rst_err_pos", err_pos, 0);
        check("rst_cnt_corr", cnt_corr, 0);
        check("rst_cnt_uncorr", cnt_uncorr, 0);

        // Clean word and two-cycle latency.
        @(negedge clk);
        out_ready = 1'b1;
        send(AN_W'(1300));
        #1 check("latency_not_early", out_valid, 0);
        @(negedge clk);
        #1 check("latency_2clk", out_valid, 1);
        @(negedge clk);

        // HL repair, inconsistent syndrome, quotient overflow.
        send(AN_W'(1044));
        send(AN_W'(1304));
        send(AN_W'(4095));
        repeat (4) @(negedge clk);
        check("directed_cnt_corr", cnt_corr, 1);
        check("directed_cnt_uncorr", cnt_uncorr, 2);

        // Backpressure: two accepts fill the pipe, third word waits.
        out_ready = 1'b0;
        send(AN_W'(1300));
        send(AN_W'(1044));
        in_valid = 1'b1;
        an_in    = AN_W'(2600);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready_low", in_ready, 0);
            check("bp_hold_n_out", n_out, 100);
            @(negedge clk);
        end
        out_ready = 1'b1;
        base = consumed;
        send(AN_W'(2600));
        @(negedge clk);
        #3 check("bp_no_bubble", consumed, base + 3);
        @(negedge clk);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(AN_W'(1300));
        send(AN_W'(2600));
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_cnt_corr", cnt_corr, 0);
        check("midrst_cnt_uncorr", cnt_uncorr, 0);
        check("midrst_in_ready", in_ready, 1);
        sb.delete();
        m_cnt_corr   = 0;
        m_cnt_uncorr = 0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 check("post_rst_no_output", out_valid, 0);
        end

        // Randomized stream with random backpressure and clears.
        @(negedge clk);
        bp_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(3) == 0) repeat ($urandom_range(2) + 1) @(negedge clk);
            send(rand_word());
        end
        @(negedge clk);
        bp_rand   = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        check("drain_empty", sb.size(), 0);

        // Clear wins over a same-cycle corrected-word handshake.
        @(negedge clk);
        send(AN_W'(1044));
        @(negedge clk);
        clr_cnt = 1'b1;
        #1 check("clr_handshake_valid", out_valid, 1);
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        check("clr_priority_cnt_corr", cnt_corr, 0);
        check("clr_priority_cnt_uncorr", cnt_uncorr, 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
